// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns one decoded memory op into a single
// handshake on a variable-latency word memory, with lane steering and load extension.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        trunkMode,
  input  logic              ShiftToTrunk,
  input  logic              sinSigno,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic [ADDR_W-3:0] memAddrReg;
  logic              memWeReg;
  logic [3:0]        memBeReg;
  logic [31:0]       memWdataReg;
  logic [1:0]        sizeReg;
  logic [1:0]        offReg;
  logic              zeroExtReg;
  logic [31:0]       loadDataReg;
  logic              loadValidReg, misalignReg, timeoutReg;

  logic        isWord, isHalf, accept, badAccess, legal, ackTake, timedOut;
  logic [1:0]  off;
  logic [3:0]  beNext;
  logic [31:0] wdataNext, shifted, extData;
  logic        latWord, latHalf;

  assign isWord    = (trunkMode == 2'b00) || (trunkMode == 2'b11);
  assign isHalf    = (trunkMode == 2'b01);
  assign off       = ShiftToTrunk ? addr[1:0] : 2'b00;
  assign accept    = (stateReg != BUSY) && op_valid && (MemRead || MemWrite);
  // Read+write together is reported through the same error path as misalignment.
  assign badAccess = (MemRead && MemWrite) ||
                     (ShiftToTrunk && ((isWord && (addr[1:0] != 2'b00)) || (isHalf && addr[0])));
  assign legal     = accept && !badAccess;
  assign beNext    = isWord ? 4'b1111 : (isHalf ? (4'b0011 << off) : (4'b0001 << off));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdataNext[8*gi +: 8] = isWord ? store_data[8*gi +: 8] :
                                    (isHalf ? store_data[8*(gi%2) +: 8] : store_data[7:0]);
    end
  endgenerate

  assign ackTake  = (stateReg == BUSY) && mem_ack;
  assign timedOut = (stateReg == BUSY) && !mem_ack && (cntReg == CNT_W'(TIMEOUT - 1));

  assign latWord = (sizeReg == 2'b00) || (sizeReg == 2'b11);
  assign latHalf = (sizeReg == 2'b01);
  assign shifted = mem_rdata >> {offReg, 3'b000};
  assign extData = latWord ? mem_rdata :
                   (latHalf ? {{16{~zeroExtReg & shifted[15]}}, shifted[15:0]}
                            : {{24{~zeroExtReg & shifted[7]}}, shifted[7:0]});

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      BUSY: begin
        if (mem_ack) begin
          stateNext = DONE;
          cntNext   = '0;
        end else if (timedOut) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      default: begin
        stateNext = legal ? BUSY : IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      memAddrReg   <= '0;
      memWeReg     <= 1'b0;
      memBeReg     <= 4'b0000;
      memWdataReg  <= '0;
      sizeReg      <= 2'b00;
      offReg       <= 2'b00;
      zeroExtReg   <= 1'b0;
      loadDataReg  <= '0;
      loadValidReg <= 1'b0;
      misalignReg  <= 1'b0;
      timeoutReg   <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      misalignReg  <= accept && badAccess;
      timeoutReg   <= timedOut;
      loadValidReg <= ackTake && !memWeReg;
      if (legal) begin
        memAddrReg  <= addr[ADDR_W-1:2];
        memWeReg    <= MemWrite;
        memBeReg    <= beNext;
        memWdataReg <= wdataNext;
        sizeReg     <= trunkMode;
        offReg      <= off;
        zeroExtReg  <= sinSigno;
      end
      if (ackTake && !memWeReg) loadDataReg <= extData;
    end
  end

  // Gated by rst_n so an accept-cycle stall cannot leak out while reset is held.
  assign stall        = rst_n && ((stateReg == BUSY) || legal);
  assign mem_req      = (stateReg == BUSY);
  assign mem_we       = memWeReg;
  assign mem_addr     = memAddrReg;
  assign mem_be       = memBeReg;
  assign mem_wdata    = memWdataReg;
  assign load_valid   = loadValidReg;
  assign load_data    = loadDataReg;
  assign misalign_err = misalignReg;
  assign timeout_err  = timeoutReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests/responses are queued
// by the stimulus and checked by independent monitors.
module tb_mem_access_unit;

  localparam int K_LOAD = 0, K_MIS = 1, K_TO = 2;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chkWd;
    int          len;
  } req_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 0, rst_n = 0;
  logic        op_valid = 0, MemRead = 0, MemWrite = 0, ShiftToTrunk = 0, sinSigno = 0;
  logic [1:0]  trunkMode = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata, load_data, mem_wdata;
  logic        mem_ack, mem_req, mem_we, stall, load_valid, misalign_err, timeout_err;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .trunkMode(trunkMode), .ShiftToTrunk(ShiftToTrunk), .sinSigno(sinSigno), .addr(addr),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0, cyc = 0;
  int   ackDelay = 0;
  logic [31:0] rdataVal = 0;
  req_t reqQ[$];
  rsp_t rspQ[$];
  int   lastStart = 0, prevStart = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else
      $display("ok   %s: 0x%08h", nm, act);
  endtask

  task automatic pushReq(input logic we, input logic [29:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic chkWd, input int len);
    req_t r;
    r.we = we; r.addr = a; r.be = be; r.wdata = wd; r.chkWd = chkWd; r.len = len;
    reqQ.push_back(r);
  endtask

  task automatic pushRsp(input int kind, input logic [31:0] d);
    rsp_t r;
    r.kind = kind; r.data = d;
    rspQ.push_back(r);
  endtask

  // Memory model: ack on the ackDelay-th BUSY cycle (0 = never).
  initial begin
    int busyCnt = 0;
    mem_ack = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        busyCnt++;
        if (ackDelay != 0 && busyCnt == ackDelay) begin
          mem_ack = 1; mem_rdata = rdataVal;
        end else begin
          mem_ack = 0; mem_rdata = 32'h5A5A_5A5A;
        end
      end else begin
        busyCnt = 0; mem_ack = 0;
      end
    end
  end

  // Request monitor: compare fields at mem_req rise and run length at its fall.
  initial begin
    logic prevReq = 0;
    int   runLen = 0;
    req_t cur;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (mem_req && !prevReq) begin
        prevStart = lastStart; lastStart = cyc; runLen = 1;
        if (reqQ.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          cur = reqQ.pop_front();
          chk("req_we", {31'd0, mem_we}, {31'd0, cur.we});
          chk("req_addr", {2'b00, mem_addr}, {2'b00, cur.addr});
          chk("req_be", {28'd0, mem_be}, {28'd0, cur.be});
          if (cur.chkWd) chk("req_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) runLen++;
      else if (prevReq && cur.len >= 0) chk("req_len", runLen, cur.len);
      prevReq = mem_req;
    end
  end

  // Response monitor: every load_valid / error pulse consumes one expected entry.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (load_valid || misalign_err || timeout_err) begin
        if (rspQ.size() == 0) chk("unexpected_rsp", {29'd0, load_valid, misalign_err, timeout_err}, 32'd0);
        else begin
          r = rspQ.pop_front();
          if (r.kind == K_LOAD) begin
            chk("rsp_is_load", {31'd0, load_valid}, 32'd1);
            chk("load_data", load_data, r.data);
          end else if (r.kind == K_MIS)
            chk("rsp_misalign", {30'd0, misalign_err, timeout_err}, 32'd2);
          else
            chk("rsp_timeout", {30'd0, misalign_err, timeout_err}, 32'd1);
        end
      end
    end
  end

  // Drive one op at a negedge, count stall cycles, return just after the first stall-free sample.
  task automatic runOp(input logic rd, input logic wr, input logic [1:0] tm, input logic sh,
                       input logic sg, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdv, input int delay, input int expStall, input string nm);
    int n = 0;
    op_valid = 1; MemRead = rd; MemWrite = wr; trunkMode = tm; ShiftToTrunk = sh;
    sinSigno = sg; addr = a; store_data = sd; ackDelay = delay; rdataVal = rdv;
    #1;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
      op_valid = 0;
      #1;
    end
    if (n == 0) begin
      @(negedge clk);
      op_valid = 0;
    end
    chk({"stall_", nm}, n, expStall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_outputs", {23'd0, load_valid, misalign_err, timeout_err, mem_we, mem_be, 1'b0}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    rst_n = 1;
    @(negedge clk);

    pushReq(0, 30'h4, 4'b1111, 0, 0, 3); pushRsp(K_LOAD, 32'h8765_4321);
    runOp(1, 0, 2'b00, 0, 0, 32'h10, 0, 32'h8765_4321, 3, 4, "lw");
    @(negedge clk);
    chk("load_data_hold", load_data, 32'h8765_4321);

    pushReq(0, 30'h4, 4'b1000, 0, 0, 1); pushRsp(K_LOAD, 32'hFFFF_FF80);
    runOp(1, 0, 2'b10, 1, 0, 32'h13, 0, 32'h80FF_1234, 1, 2, "lb");
    @(negedge clk);
    pushReq(0, 30'h4, 4'b1000, 0, 0, 1); pushRsp(K_LOAD, 32'h0000_0080);
    runOp(1, 0, 2'b10, 1, 1, 32'h13, 0, 32'h80FF_1234, 1, 2, "lbu");
    @(negedge clk);
    pushReq(1, 30'h8, 4'b1100, 32'hBEEF_BEEF, 1, 2);
    runOp(0, 1, 2'b01, 1, 0, 32'h22, 32'hDEAD_BEEF, 0, 2, 3, "sh");
    @(negedge clk);
    pushReq(0, 30'h0, 4'b1100, 0, 0, 1); pushRsp(K_LOAD, 32'hFFFF_9ABC);
    runOp(1, 0, 2'b01, 1, 0, 32'h2, 0, 32'h9ABC_0000, 1, 2, "lh");
    @(negedge clk);
    pushReq(0, 30'h4, 4'b0001, 0, 0, 2); pushRsp(K_LOAD, 32'h0000_0034);
    runOp(1, 0, 2'b10, 0, 0, 32'h13, 0, 32'h80FF_1234, 2, 3, "lb_lane0");
    @(negedge clk);
    pushReq(0, 30'h2, 4'b1111, 0, 0, 1); pushRsp(K_LOAD, 32'h0000_8001);
    runOp(1, 0, 2'b11, 1, 0, 32'h8, 0, 32'h0000_8001, 1, 2, "lw_tm11");
    @(negedge clk);

    pushRsp(K_MIS, 0);
    runOp(1, 0, 2'b00, 1, 0, 32'h06, 0, 0, 1, 0, "lw_misalign");
    @(negedge clk);
    pushRsp(K_MIS, 0);
    runOp(1, 1, 2'b00, 0, 0, 32'h10, 0, 0, 1, 0, "rd_wr_illegal");
    @(negedge clk);
    pushRsp(K_MIS, 0);
    runOp(0, 1, 2'b01, 1, 0, 32'h21, 32'h1234, 0, 1, 0, "sh_misalign");
    @(negedge clk);

    pushReq(0, 30'h5, 4'b1111, 0, 0, 16); pushRsp(K_TO, 0);
    runOp(1, 0, 2'b00, 0, 0, 32'h14, 0, 0, 0, 17, "timeout");
    chk("timeout_idle", {30'd0, mem_req, stall}, 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a transaction.
    pushReq(0, 30'h6, 4'b1111, 0, 0, -1);
    op_valid = 1; MemRead = 1; MemWrite = 0; trunkMode = 2'b00; ShiftToTrunk = 0;
    addr = 32'h18; ackDelay = 0;
    @(negedge clk);
    op_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pushReq(0, 30'hC, 4'b1111, 0, 0, 1); pushRsp(K_LOAD, 32'h1357_2468);
    runOp(1, 0, 2'b00, 0, 0, 32'h30, 0, 32'h1357_2468, 1, 2, "lw_after_rst");
    @(negedge clk);

    // Back-to-back: the LW is presented in the SW's DONE cycle.
    pushReq(1, 30'h10, 4'b1111, 32'h1122_3344, 1, 1);
    runOp(0, 1, 2'b00, 0, 0, 32'h40, 32'h1122_3344, 0, 1, 2, "sw_b2b");
    pushReq(0, 30'h11, 4'b1111, 0, 0, 1); pushRsp(K_LOAD, 32'hCAFE_F00D);
    runOp(1, 0, 2'b00, 0, 0, 32'h44, 0, 32'hCAFE_F00D, 1, 2, "lw_b2b");
    chk("b2b_req_gap", lastStart - prevStart, 2);

    repeat (4) @(negedge clk);
    chk("req_queue_empty", reqQ.size(), 0);
    chk("rsp_queue_empty", rspQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the main decoder's memory control bundle (MemRead, MemWrite, trunkMode, ShiftToTrunk, sinSigno), placed in the MEM stage.
- Turns each load or store into one handshake transaction on a variable-latency word-wide data memory.
- Generates byte-lane enables and store-data replication, extracts and extends load data, and stalls the pipeline until the transaction completes.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum number of cycles in BUSY waiting for mem_ack before the access is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  MEM-stage instruction valid.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- trunkMode  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- ShiftToTrunk  in  1  1: lane selected by addr low bits; 0: lane 0.
- sinSigno  in  1  1: zero-extend loads; 0: sign-extend loads.
- addr  in  ADDR_W  byte address (ALU result).
- store_data  in  32  rt value to be stored.
- mem_req  out  1  memory request.
- mem_we  out  1  1 write, 0 read.
- mem_addr  out  ADDR_W-2  word address.
- mem_be  out  4  byte enables, bit k covers bits [8k+7:8k] (little-endian).
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  transaction complete.
- stall  out  1  freeze the pipeline upstream of MEM.
- load_valid  out  1  one-cycle pulse, load_data valid.
- load_data  out  32  extended load result.
- misalign_err  out  1  one-cycle pulse.
- timeout_err  out  1  one-cycle pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - All outputs 0; mem_req drops immediately, including mid-transaction.
  - Any in-flight access is discarded; no load_valid is produced for it.
- Accepting an access (state IDLE or DONE): op_valid=1 with MemRead or MemWrite set.
- Lane offset: off = ShiftToTrunk ? addr[1:0] : 2'b00.
- Alignment and legality checks:
  - Misaligned when ShiftToTrunk=1 and either word size with addr[1:0]!=0, or half size with addr[0]=1.
  - MemRead=1 and MemWrite=1 together is illegal and reported as misalign_err.
  - A misaligned or illegal access issues no memory transaction and does not assert stall.
  - misalign_err pulses on the next cycle; state goes to IDLE.
- Legal access: latch mem_addr=addr[ADDR_W-1:2], mem_we=MemWrite, size, off, sinSigno; go to BUSY.
  - stall=1 combinationally in the accept cycle.
- Byte enables:
  - word: 1111.
  - half: 0011<<off.
  - byte: 0001<<off.
- Write data:
  - word: store_data.
  - half: {2{store_data[15:0]}}.
  - byte: {4{store_data[7:0]}}.
- BUSY state:
  - mem_req=1, stall=1; request fields held stable until mem_ack.
  - Counter increments each BUSY cycle.
  - mem_ack=1: capture mem_rdata, go to DONE, clear counter.
  - Counter reaches TIMEOUT-1 without mem_ack: drop mem_req, pulse timeout_err next cycle, go to IDLE, no load_valid.
  - mem_ack and timeout in the same cycle: mem_ack wins.
- DONE state (one cycle):
  - stall=0, mem_req=0.
  - For loads, load_valid=1 and load_data = extracted field.
    - byte: rdata[8*off+7:8*off].
    - half: rdata[8*off+15:8*off].
    - Extended to 32 bits, zero-extended if sinSigno=1, otherwise sign-extended.
    - word: rdata unchanged.
  - For stores, load_valid=0.
  - A new access may be accepted in DONE (back-to-back); otherwise the next state is IDLE.
- mem_ack outside BUSY is ignored.
- load_data holds its last value between pulses.
- op_valid=0, or neither MemRead nor MemWrite set, means no action and stall=0.
- Minimum latency: accept cycle, then BUSY with ack in the first BUSY cycle, then DONE. Stall lasts 2 cycles.

Test Plan:
- LW at addr=0x0000_0010, rdata=0x8765_4321, ack on 3rd BUSY cycle -> mem_addr=0x4, be=1111, stall high 4 cycles, load_valid with load_data=0x8765_4321.
- LB with ShiftToTrunk=1, sinSigno=0, addr=0x13, rdata=0x80FF_1234 -> be=1000, load_data=0xFFFF_FF80; repeat as LBU (sinSigno=1) -> 0x0000_0080.
- SH with ShiftToTrunk=1, addr=0x22, store_data=0xDEAD_BEEF -> mem_we=1, be=1100, wdata=0xBEEF_BEEF, no load_valid.
- LW at addr=0x06 -> no mem_req, stall=0, misalign_err pulse one cycle later; MemRead and MemWrite both high -> same response.
- TIMEOUT=16 with mem_ack never asserted -> mem_req high exactly 16 cycles, then timeout_err pulse, state IDLE, stall low.
- rst_n low during BUSY -> mem_req and stall drop without waiting for clk; after release, a fresh LW completes normally.
- Back-to-back SW then LW, second accepted in DONE -> no idle cycle between transactions.
